// File: rtl/pfa_serial_seq.sv
// -----------------------------------------------------------------------------
// pfa_serial_seq
//   Bit-serial adder controller. One external PFA cell is time-shared across
//   every bit of a WIDTH-bit addition. Operands are latched on an accepted
//   start, fed to the PFA LSB first (one bit per cycle), and the returning
//   S/G/P are folded into the sum, the ripple carry and the group
//   generate/propagate terms.
//
//   Timing: start sampled at edge 0, RUN during cycles 1..WIDTH, done_o pulses
//   in cycle WIDTH+1 (FIN), IDLE again in cycle WIDTH+2.
//
// Optional build macro:
//   PFA_SEQ_OVF_EN - adds ovf_o (two's-complement overflow: carry into the MSB
//                    XOR carry out of the MSB), registered with the results.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start_i              request, accepted only in IDLE
//   a_i, b_i, cin_i      operands and carry-in, sampled on accepted start
//   pfa_a_o/b_o/c_o      bit-serial drive to the PFA cell (0 outside RUN)
//   pfa_s_i/g_i/p_i      PFA sum, generate (A&B) and propagate (A|B) return
//   busy_o               high in RUN and FIN
//   done_o               one-cycle completion pulse (FIN)
//   sum_o, cout_o        result and final carry, held until the next FIN
//   g_grp_o, p_grp_o     group generate / propagate over all bits
//   ovf_o                (PFA_SEQ_OVF_EN only) signed overflow flag
// -----------------------------------------------------------------------------
module pfa_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             pfa_a_o,
  output logic             pfa_b_o,
  output logic             pfa_c_o,
  input  logic             pfa_s_i,
  input  logic             pfa_g_i,
  input  logic             pfa_p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             g_grp_o,
`ifdef PFA_SEQ_OVF_EN
  output logic             p_grp_o,
  output logic             ovf_o
`else
  output logic             p_grp_o
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  // Only the upper WIDTH-1 sum bits need storage: the final bit arrives on the
  // last RUN edge and is taken straight from s_sh_d into sum_q.
  logic [WIDTH-1:1] s_sh_q;
  logic             carry_q, gg_q, pg_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, cout_q, g_grp_q, p_grp_q;
  logic [WIDTH-1:0] sum_q;
`ifdef PFA_SEQ_OVF_EN
  logic             c_msb_q, ovf_q;
`endif

  // Per-bit update terms from the PFA return path.
  logic [WIDTH-1:0] s_sh_d;
  logic             carry_d, gg_d, pg_d;
  logic             last_bit;

  assign s_sh_d   = {pfa_s_i, s_sh_q};
  assign carry_d  = pfa_g_i | (pfa_p_i & carry_q);
  assign gg_d     = pfa_g_i | (pfa_p_i & gg_q);
  assign pg_d     = pg_q & pfa_p_i;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // The PFA is driven only while RUN so that it sees quiet zeros otherwise,
  // including immediately when reset aborts an operation.
  assign pfa_a_o = (state_q == S_RUN) & a_sh_q[0];
  assign pfa_b_o = (state_q == S_RUN) & b_sh_q[0];
  assign pfa_c_o = (state_q == S_RUN) & carry_q;

  // NOTE: every register here is plain state (no memory arrays), so all of it
  // is cleared by the asynchronous reset, and all updates use non-blocking
  // assignments so that each right-hand side sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      gg_q    <= 1'b0;
      pg_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      g_grp_q <= 1'b0;
      p_grp_q <= 1'b0;
`ifdef PFA_SEQ_OVF_EN
      c_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            carry_q <= cin_i;
            cnt_q   <= '0;
            gg_q    <= 1'b0;
            pg_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          s_sh_q  <= s_sh_d[WIDTH-1:1];
          carry_q <= carry_d;
          gg_q    <= gg_d;
          pg_q    <= pg_d;
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CW'(1);
`ifdef PFA_SEQ_OVF_EN
          // Carry produced by bit WIDTH-2 is the carry into the MSB.
          if (cnt_q == CW'(WIDTH - 2)) c_msb_q <= carry_d;
`endif
          // Results are captured on the FIN entry edge so they are valid
          // in the same cycle that done_o is high.
          if (last_bit) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            sum_q   <= s_sh_d;
            cout_q  <= carry_d;
            g_grp_q <= gg_d;
            p_grp_q <= pg_d;
`ifdef PFA_SEQ_OVF_EN
            ovf_q   <= c_msb_q ^ carry_d;
`endif
          end
        end

        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign g_grp_o = g_grp_q;
  assign p_grp_o = p_grp_q;
`ifdef PFA_SEQ_OVF_EN
  assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_pfa_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_pfa_serial_seq
//   Self-checking bench for pfa_serial_seq (WIDTH=8). A behavioural PFA cell
//   closes the loop; expected results come from plain integer addition and
//   are queued when a start is accepted, then popped by a monitor on done_o.
// -----------------------------------------------------------------------------
module tb_pfa_serial_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         gg;
    logic         pg;
    logic         ovf;
  } exp_t;

  logic         clk, rst_n, start_i, cin_i;
  logic [W-1:0] a_i, b_i, sum_o;
  logic         pfa_a_o, pfa_b_o, pfa_c_o, pfa_s_i, pfa_g_i, pfa_p_i;
  logic         busy_o, done_o, cout_o, g_grp_o, p_grp_o;
`ifdef PFA_SEQ_OVF_EN
  logic         ovf_o;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  pfa_serial_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .pfa_a_o (pfa_a_o),
    .pfa_b_o (pfa_b_o),
    .pfa_c_o (pfa_c_o),
    .pfa_s_i (pfa_s_i),
    .pfa_g_i (pfa_g_i),
    .pfa_p_i (pfa_p_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .g_grp_o (g_grp_o),
`ifdef PFA_SEQ_OVF_EN
    .p_grp_o (p_grp_o),
    .ovf_o   (ovf_o)
`else
    .p_grp_o (p_grp_o)
`endif
  );

  // Behavioural PFA cell.
  assign pfa_s_i = pfa_a_o ^ pfa_b_o ^ pfa_c_o;
  assign pfa_g_i = pfa_a_o & pfa_b_o;
  assign pfa_p_i = pfa_a_o | pfa_b_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference results from whole-word arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t    e;
    longint  full, gen, lo;
    full   = longint'(a) + longint'(b) + longint'(c);
    gen    = longint'(a) + longint'(b);
    lo     = longint'(a[W-2:0]) + longint'(b[W-2:0]) + longint'(c);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.gg   = gen[W];
    e.pg   = &(a | b);
    e.ovf  = lo[W-1] ^ full[W];
    return e;
  endfunction

  // Carry into bit i of a+b+c.
  function automatic logic carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c, input int i);
    longint mask, s;
    mask = (longint'(1) << i) - 1;
    s    = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
    return s[i];
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sum",   32'(sum_o),   32'(e.sum));
        check("cout",  32'(cout_o),  32'(e.cout));
        check("g_grp", 32'(g_grp_o), 32'(e.gg));
        check("p_grp", 32'(p_grp_o), 32'(e.pg));
`ifdef PFA_SEQ_OVF_EN
        check("ovf",   32'(ovf_o),   32'(e.ovf));
`endif
      end
    end
  end

  // Waits (bounded) for IDLE, then presents one start pulse; returns just
  // after the accepting edge, i.e. in RUN cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy_o), 32'd0);
    a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b, c));
    #1 start_i = 1'b0;
  endtask

  // Follows one operation cycle by cycle: PFA drive, busy and done timing.
  // A spurious start (with a_i=ign_a) is pulsed in RUN cycle ign_cyc if >0.
  task automatic watch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int ign_cyc, input logic [W-1:0] ign_a);
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      @(negedge clk);
      start_i = (cyc == ign_cyc);
      if (cyc == ign_cyc) a_i = ign_a;
      check($sformatf("busy_c%0d", cyc), 32'(busy_o), 32'(cyc <= W + 1));
      check($sformatf("done_c%0d", cyc), 32'(done_o), 32'(cyc == W + 1));
      if (cyc <= W) begin
        check($sformatf("pfa_a_c%0d", cyc), 32'(pfa_a_o), 32'(a[cyc-1]));
        check($sformatf("pfa_b_c%0d", cyc), 32'(pfa_b_o), 32'(b[cyc-1]));
        check($sformatf("pfa_c_c%0d", cyc), 32'(pfa_c_o), 32'(carry_in(a, b, c, cyc - 1)));
      end else begin
        check($sformatf("pfa_idle_c%0d", cyc), 32'({pfa_a_o, pfa_b_o, pfa_c_o}), 32'd0);
      end
    end
    start_i = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } op_t;

  op_t dir_ops[6] = '{
    '{8'h5A, 8'h3C, 1'b0},
    '{8'hFF, 8'h01, 1'b0},
    '{8'hFF, 8'h00, 1'b1},
    '{8'h7F, 8'h01, 1'b0},
    '{8'h80, 8'h80, 1'b1},
    '{8'h00, 8'h00, 1'b0}
  };

  initial begin
    int n;
    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sum",  32'(sum_o),  32'd0);
    check("rst_flags", 32'({cout_o, g_grp_o, p_grp_o}), 32'd0);
    check("rst_pfa",  32'({pfa_a_o, pfa_b_o, pfa_c_o}), 32'd0);
`ifdef PFA_SEQ_OVF_EN
    check("rst_ovf",  32'(ovf_o), 32'd0);
`endif
    rst_n = 1'b1;

    // Directed operations with full per-cycle observation.
    foreach (dir_ops[k]) begin
      issue(dir_ops[k].a, dir_ops[k].b, dir_ops[k].c);
      watch(dir_ops[k].a, dir_ops[k].b, dir_ops[k].c, 0, '0);
    end

    // Start pulsed mid-RUN must be ignored and not queued.
    issue(8'h12, 8'h34, 1'b0);
    watch(8'h12, 8'h34, 1'b0, 3, 8'hFF);

    // Start held high: restart on the first IDLE cycle, period W+2.
    @(negedge clk);
    a_i = 8'hA5; b_i = 8'h5A; cin_i = 1'b1; start_i = 1'b1;
    sb.push_back(model(8'hA5, 8'h5A, 1'b1));
    for (int cyc = 1; cyc <= 2 * W + 5; cyc++) begin
      @(negedge clk);
      if (cyc == W + 2) begin
        a_i = 8'hC3; b_i = 8'h77; cin_i = 1'b0;
        sb.push_back(model(8'hC3, 8'h77, 1'b0));
      end
      if (cyc == W + 3) start_i = 1'b0;
      check($sformatf("held_done_c%0d", cyc), 32'(done_o),
            32'((cyc == W + 1) || (cyc == 2 * W + 3)));
    end

    // Reset in RUN cycle 4 aborts with no done.
    issue(8'h9C, 8'h4E, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_sum",  32'(sum_o),  32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_pfa",  32'({pfa_a_o, pfa_b_o, pfa_c_o}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_o), 32'd0);
    end
    issue(8'h3B, 8'hD9, 1'b0);
    watch(8'h3B, 8'hD9, 1'b0, 0, '0);

    // Randomized back-to-back traffic, checked by the monitor.
    for (int k = 0; k < 40; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
